multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: op  input  7  opcode from instruction register.
REQ-004 SHALL have port: funct3  input  3  instr[14:12].
REQ-005 SHALL have port: funct7  input  1  instr[30].
REQ-006 SHALL have port: Zero, Sign  input  1 each  ALU flags, current cycle.
REQ-007 SHALL have port: mem_ready  input  1  memory completes access this cycle.
REQ-008 SHALL have ports: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each.
REQ-009 SHALL have ports: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each; AluControl  output  3.
REQ-010 SHALL have ports: state  output  4  current state code; illegal  output  1  registered sticky undefined-opcode flag.

Function
REQ-011 SHALL implement a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH.
REQ-012 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, AluControl=000, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-013 DECODE: ALUSrcA=01, ALUSrcB=01, AluControl=000, for branch target; go to MEMADR (op 0000011 or 0100011), EXECR (0110011), EXECI (0010011), BRANCH (1100011), else FETCH with illegal set to 1.
REQ-014 MEMADR: ALUSrcA=10, ALUSrcB=01, AluControl=000; go to MEMREAD for lw, MEMWRITE for sw.
REQ-015 MEMREAD: ResultSrc=00, AdrSrc=1; wait on mem_ready, then MEMWB.
REQ-016 MEMWB: ResultSrc=01, RegWrite=1; then FETCH.
REQ-017 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until the mem_ready=1 cycle inclusive; then FETCH.
REQ-018 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; both go to ALUWB.
REQ-019 ALUWB: ResultSrc=00, RegWrite=1; then FETCH.
REQ-020 BRANCH: ALUSrcA=10, ALUSrcB=00, AluControl=010, ResultSrc=00; PCWrite=Zero (funct3 000), ~Zero (001), Sign (100), 0 otherwise; then FETCH.
REQ-021 AluControl in EXECR/EXECI SHALL decode funct3: 000 gives 010 when funct7=1 and op[5]=1, else 000; 001 gives 001; 100, 101, 110 and 111 pass through unchanged; 010 and 011 give 000.
REQ-022 ImmSrc SHALL be 00 in EXECI and for lw, 01 for sw, and 10 in DECODE/BRANCH for branch; 00 otherwise.
REQ-023 Every output not listed for a state SHALL be 0; PCWrite, MemWrite, RegWrite, IRWrite SHALL never assert outside listed states.
REQ-024 CPI SHALL be, with mem_ready=1 throughout: lw 5, sw 4, R/I 4, branch 3; each cycle of mem_ready=0 in FETCH/MEMREAD/MEMWRITE SHALL add exactly one cycle.
REQ-025 illegal SHALL stay 1 until reset; the FSM SHALL continue to fetch after an illegal opcode.

Reset
REQ-026 rst=0 SHALL force state=FETCH and illegal=0 immediately, independent of clk; outputs SHALL then show FETCH values, with IRWrite/PCWrite still gated by mem_ready.
REQ-027 A reset mid-instruction SHALL abandon it; no RegWrite or MemWrite SHALL occur in the cycle after release unless FETCH rules require it.
REQ-028 On the first rising edge after rst goes 1, the FSM SHALL evaluate FETCH normally.

Verification
REQ-029 lw, op=0000011, mem_ready=1: states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4.
REQ-030 sw, op=0100011, mem_ready low for 2 cycles in MEMWRITE: MemWrite=1 for 3 cycles; ImmSrc=01 in MEMADR; back to FETCH.
REQ-031 bne, funct3=001, Zero=0: PCWrite=1 in BRANCH; with Zero=1, PCWrite=0; funct3=010 gives PCWrite=0.
REQ-032 sub, op=0110011, funct3=000, funct7=1: AluControl=010 in EXECR; addi with funct7=1 (op[5]=0) gives 000.
REQ-033 op=1111111: DECODE leads to FETCH and illegal=1 from the next cycle, kept through later valid instructions.
REQ-034 rst=0 asserted in MEMREAD between clock edges: state=0 immediately; RegWrite never asserts for the aborted lw.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch,
// decode, memory, ALU and branch steps, plus a sticky illegal flag.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       Sign,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] AluControl,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [2:0] alu_dec;
    logic       take_br;

    assign state   = state_q;
    assign illegal = illegal_q;

    // ALU operation selected by funct3/funct7 for register and immediate ops
    always_comb begin
        alu_dec = 3'b000;
        case (funct3)
            3'b000:         alu_dec = (funct7 && op[5]) ? 3'b010 : 3'b000;
            3'b001:         alu_dec = 3'b001;
            3'b010, 3'b011: alu_dec = 3'b000;
            default:        alu_dec = funct3;
        endcase
    end

    // Branch condition from the ALU flags of the compare cycle
    always_comb begin
        take_br = 1'b0;
        case (funct3)
            3'b000:  take_br = Zero;
            3'b001:  take_br = ~Zero;
            3'b100:  take_br = Sign;
            default: take_br = 1'b0;
        endcase
    end

    // Next state, sticky illegal update and per-state control outputs
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        AluControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (op == OP_BR) begin
                    ImmSrc = 2'b10;
                end
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_R) begin
                    state_d = S_EXECR;
                end else if (op == OP_I) begin
                    state_d = S_EXECI;
                end else if (op == OP_BR) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op[5]) begin
                    ImmSrc  = 2'b01;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                AluControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                AluControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                AluControl = 3'b010;
                ImmSrc     = 2'b10;
                PCWrite    = take_br;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and illegal-flag registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for the multicycle controller: per-cycle
// expected state/outputs queued with stimulus, compared at negedge.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       Sign;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] AluControl;
    logic [3:0] state;
    logic       illegal;
    logic [20:0] obs;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3),
        .funct7(funct7), .Zero(Zero), .Sign(Sign),
        .mem_ready(mem_ready), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .AluControl(AluControl), .state(state),
        .illegal(illegal)
    );

    assign obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite,
                  RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, AluControl, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        mr;
        logic        z;
        logic        s;
        logic [20:0] v;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       exp_ill;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // Reference table of required outputs per state
    function automatic logic [20:0] exp_out(
        input logic [3:0] st, input logic [6:0] o,
        input logic [2:0] f3, input logic f7, input logic z,
        input logic s, input logic mr, input logic ill);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sbx, imm;
        logic [2:0] alu;
        {pcw, adr, mw, irw, rw} = 5'b0;
        rs = 2'b00; sa = 2'b00; sbx = 2'b00;
        imm = 2'b00; alu = 3'b000;
        case (st)
            4'd0: begin
                sbx = 2'b10; rs = 2'b10; irw = mr; pcw = mr;
            end
            4'd1: begin
                sa = 2'b01; sbx = 2'b01;
                if (o == BR) imm = 2'b10;
            end
            4'd2: begin
                sa = 2'b10; sbx = 2'b01;
                if (o == SW) imm = 2'b01;
            end
            4'd3: adr = 1'b1;
            4'd4: begin rs = 2'b01; rw = 1'b1; end
            4'd5: begin adr = 1'b1; mw = 1'b1; end
            4'd6, 4'd7: begin
                sa = 2'b10;
                sbx = (st == 4'd7) ? 2'b01 : 2'b00;
                if (f3 == 3'b000) alu = (f7 && o[5]) ? 3'b010 : 3'b000;
                else if (f3 == 3'b001) alu = 3'b001;
                else if (f3[2]) alu = f3;
                else alu = 3'b000;
            end
            4'd8: rw = 1'b1;
            4'd9: begin
                sa = 2'b10; alu = 3'b010; imm = 2'b10;
                if (f3 == 3'b000) pcw = z;
                else if (f3 == 3'b001) pcw = ~z;
                else if (f3 == 3'b100) pcw = s;
            end
            default: ;
        endcase
        return {st, pcw, adr, mw, irw, rw, rs, sa, sbx, imm, alu, ill};
    endfunction

    // Queue one expected cycle with the stimulus that goes with it
    task automatic plan(input logic [3:0] st, input logic mr,
                        input logic z, input logic s);
        exp_t e;
        e.op = cur_op; e.f3 = cur_f3; e.f7 = cur_f7;
        e.mr = mr; e.z = z; e.s = s;
        e.v = exp_out(st, cur_op, cur_f3, cur_f7, z, s, mr, exp_ill);
        q.push_back(e);
    endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7);
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
    endtask

    task automatic test_reset;
        logic [20:0] w;
        rst = 1'b0; mem_ready = 1'b0; op = LW;
        funct3 = 3'b000; funct7 = 1'b0; Zero = 1'b0; Sign = 1'b0;
        #3;
        w = exp_out(4'd0, LW, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== w) begin
            n_fail++;
            $display("FAIL reset_mr0: got %h want %h", obs, w);
        end
        mem_ready = 1'b1;
        #1;
        w = exp_out(4'd0, LW, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== w) begin
            n_fail++;
            $display("FAIL reset_mr1: got %h want %h", obs, w);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== w) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", obs, w);
        end
        mem_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_ill = 1'b0;
    endtask

    task automatic test_lw;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            set_ins(LW, 3'b010, 1'b0);
            if (k == 1) plan(4'd0, 1'b0, 1'b0, 1'b0);
            plan(4'd0, 1'b1, 1'b0, 1'b0);
            plan(4'd1, 1'b1, 1'b0, 1'b0);
            plan(4'd2, 1'b1, 1'b0, 1'b0);
            if (k == 1) plan(4'd3, 1'b0, 1'b0, 1'b0);
            plan(4'd3, 1'b1, 1'b0, 1'b0);
            plan(4'd4, 1'b1, 1'b0, 1'b0);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL lw: got %h want %h", obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait;
        exp_t e;
        set_ins(SW, 3'b010, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd2, 1'b1, 1'b0, 1'b0);
        plan(4'd5, 1'b0, 1'b0, 1'b0);
        plan(4'd5, 1'b0, 1'b0, 1'b0);
        plan(4'd5, 1'b1, 1'b0, 1'b0);
        plan(4'd0, 1'b0, 1'b0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL sw_wait: got %h want %h", obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch;
        exp_t e;
        logic [2:0] f3s [6] = '{3'b001, 3'b001, 3'b010,
                                 3'b000, 3'b100, 3'b100};
        logic       zs  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       ss  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            set_ins(BR, f3s[k], 1'b0);
            plan(4'd0, 1'b1, zs[k], ss[k]);
            plan(4'd1, 1'b1, zs[k], ss[k]);
            plan(4'd9, 1'b1, zs[k], ss[k]);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL branch f3=%b: got %h want %h",
                         e.f3, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu;
        exp_t e;
        logic [6:0] ops [8] = '{RT, IT, RT, RT, RT, IT, RT, IT};
        logic [2:0] f3s [8] = '{3'b000, 3'b000, 3'b000, 3'b001,
                                 3'b011, 3'b110, 3'b101, 3'b111};
        logic       f7s [8] = '{1'b1, 1'b1, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            set_ins(ops[k], f3s[k], f7s[k]);
            plan(4'd0, 1'b1, 1'b0, 1'b0);
            plan(4'd1, 1'b1, 1'b0, 1'b0);
            plan((ops[k] == RT) ? 4'd6 : 4'd7, 1'b1, 1'b0, 1'b0);
            plan(4'd8, 1'b1, 1'b0, 1'b0);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL alu op=%b f3=%b: got %h want %h",
                         e.op, e.f3, obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal;
        exp_t e;
        set_ins(BAD, 3'b000, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        exp_ill = 1'b1;
        plan(4'd0, 1'b0, 1'b0, 1'b0);
        set_ins(IT, 3'b000, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd7, 1'b1, 1'b0, 1'b0);
        plan(4'd8, 1'b1, 1'b0, 1'b0);
        set_ins(LW, 3'b010, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd2, 1'b1, 1'b0, 1'b0);
        plan(4'd3, 1'b0, 1'b0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL illegal: got %h want %h", obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    // Entered with the lw of test_illegal parked in MEMREAD
    task automatic test_reset_mid;
        exp_t e;
        logic [20:0] w;
        #2; rst = 1'b0; #1;
        w = exp_out(4'd0, LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== w) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h want %h", obs, w);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        w = exp_out(4'd0, LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== w) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %h want %h", obs, w);
        end
        mem_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_ill = 1'b0;
        set_ins(LW, 3'b010, 1'b0);
        plan(4'd0, 1'b0, 1'b0, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd2, 1'b1, 1'b0, 1'b0);
        plan(4'd3, 1'b1, 1'b0, 1'b0);
        plan(4'd4, 1'b1, 1'b0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL reset_mid: got %h want %h", obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        set_ins(SW, 3'b010, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd2, 1'b1, 1'b0, 1'b0);
        plan(4'd5, 1'b1, 1'b0, 1'b0);
        set_ins(RT, 3'b100, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd6, 1'b1, 1'b0, 1'b0);
        plan(4'd8, 1'b1, 1'b0, 1'b0);
        set_ins(BR, 3'b000, 1'b0);
        plan(4'd0, 1'b1, 1'b1, 1'b0);
        plan(4'd1, 1'b1, 1'b1, 1'b0);
        plan(4'd9, 1'b1, 1'b1, 1'b0);
        set_ins(LW, 3'b010, 1'b0);
        plan(4'd0, 1'b1, 1'b0, 1'b0);
        plan(4'd1, 1'b1, 1'b0, 1'b0);
        plan(4'd2, 1'b1, 1'b0, 1'b0);
        plan(4'd3, 1'b1, 1'b0, 1'b0);
        plan(4'd4, 1'b1, 1'b0, 1'b0);
        plan(4'd0, 1'b0, 1'b0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            op = e.op; funct3 = e.f3; funct7 = e.f7;
            mem_ready = e.mr; Zero = e.z; Sign = e.s;
            @(negedge clk);
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL back_to_back: got %h want %h", obs, e.v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_ill = 1'b0;
        cur_op = LW; cur_f3 = 3'b000; cur_f7 = 1'b0;
        test_reset;
        test_lw;
        test_sw_wait;
        test_branch;
        test_alu;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
